pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 152 +++++++++++++++
 tb/tb_pc_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with optional return stack.
// Applies one operation per clock (HOLD, INC, JUMP, BRANCH, CALL, RET, CLEAR).
// Optional feature macro: PC_SEQ_RET_STACK_EN
//    defined   : CALL pushes the return address, RET pops it, and SP_OUT,
//                OVERFLOW and UNDERFLOW report stack state.
//    undefined : CALL behaves as JUMP, RET behaves as HOLD, SP_OUT, OVERFLOW
//                and UNDERFLOW are tied low, and no stack storage exists.
// Port names are kept in the fixed upper-case form the integration expects.

module pc_sequencer #(
   parameter int                ADDR_W      = 19,
   parameter int                OFF_W       = 8,
   parameter int                STACK_DEPTH = 4,
   parameter logic [ADDR_W-1:0] RESET_VEC   = '0,
   localparam int               SP_W        = $clog2(STACK_DEPTH + 1)
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic              STALL,
   input  logic [2:0]        OP,
   input  logic              COND,
   input  logic [ADDR_W-1:0] TARGET,
   input  logic [OFF_W-1:0]  OFFSET,
   output logic [ADDR_W-1:0] PC_OUT,
   output logic [SP_W-1:0]   SP_OUT,
   output logic              OVERFLOW,
   output logic              UNDERFLOW
);

   typedef enum logic [2:0] {
      OP_HOLD   = 3'b000,
      OP_INC    = 3'b001,
      OP_JUMP   = 3'b010,
      OP_BRANCH = 3'b011,
      OP_CALL   = 3'b100,
      OP_RET    = 3'b101,
      OP_CLEAR  = 3'b110,
      OP_RSVD   = 3'b111
   } op_e;

   op_e               w_op;
   logic [ADDR_W-1:0] w_pc_inc;
   logic [ADDR_W-1:0] w_off_sext;
   logic [ADDR_W-1:0] w_pc_branch;
   logic [ADDR_W-1:0] r_pc;

   assign w_op        = op_e'(OP);
   assign w_pc_inc    = r_pc + ADDR_W'(1);
   // Size cast of a signed operand sign-extends the displacement to PC width.
   assign w_off_sext  = ADDR_W'($signed(OFFSET));
   assign w_pc_branch = r_pc + w_off_sext;

`ifdef PC_SEQ_RET_STACK_EN

   localparam int              IDX_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

   logic [ADDR_W-1:0] r_stack [STACK_DEPTH];
   logic [SP_W-1:0]   r_sp;
   logic              r_ovf;
   logic              r_unf;
   logic              w_can_push;
   logic              w_can_pop;
   logic              w_push;
   logic [IDX_W-1:0]  w_push_idx;
   logic [IDX_W-1:0]  w_top_idx;
   logic [ADDR_W-1:0] w_top;

   assign w_can_push = (r_sp != SP_FULL);
   assign w_can_pop  = (r_sp != '0);
   assign w_push     = !STALL && (w_op == OP_CALL) && w_can_push;
   assign w_push_idx = IDX_W'(r_sp);
   assign w_top_idx  = IDX_W'(r_sp - SP_W'(1));
   assign w_top      = r_stack[w_top_idx];

   // PC, stack pointer and sticky error flags.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_pc  <= RESET_VEC;
         r_sp  <= '0;
         r_ovf <= 1'b0;
         r_unf <= 1'b0;
      end else if (!STALL) begin
         case (w_op)
            OP_INC:    r_pc <= w_pc_inc;
            OP_JUMP:   r_pc <= TARGET;
            OP_BRANCH: r_pc <= COND ? w_pc_branch : w_pc_inc;
            OP_CALL: begin
               if (w_can_push) begin
                  r_pc <= TARGET;
                  r_sp <= r_sp + SP_W'(1);
               end else begin
                  r_ovf <= 1'b1;
               end
            end
            OP_RET: begin
               if (w_can_pop) begin
                  r_pc <= w_top;
                  r_sp <= r_sp - SP_W'(1);
               end else begin
                  r_unf <= 1'b1;
               end
            end
            OP_CLEAR: begin
               r_pc  <= RESET_VEC;
               r_sp  <= '0;
               r_ovf <= 1'b0;
               r_unf <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // Return-address storage; written only on a successful push, never reset.
   always_ff @(posedge CLK) begin
      if (RESET_N && w_push) begin
         r_stack[w_push_idx] <= w_pc_inc;
      end
   end

   assign SP_OUT    = r_sp;
   assign OVERFLOW  = r_ovf;
   assign UNDERFLOW = r_unf;

`else

   // PC update without a return stack: CALL jumps, RET holds.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_pc <= RESET_VEC;
      end else if (!STALL) begin
         case (w_op)
            OP_INC:    r_pc <= w_pc_inc;
            OP_JUMP:   r_pc <= TARGET;
            OP_BRANCH: r_pc <= COND ? w_pc_branch : w_pc_inc;
            OP_CALL:   r_pc <= TARGET;
            OP_CLEAR:  r_pc <= RESET_VEC;
            default: ;
         endcase
      end
   end

   assign SP_OUT    = '0;
   assign OVERFLOW  = 1'b0;
   assign UNDERFLOW = 1'b0;

`endif

   assign PC_OUT = r_pc;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer (ADDR_W=19, OFF_W=8, STACK_DEPTH=4,
// RESET_VEC=0x100). Expectations follow PC_SEQ_RET_STACK_EN when defined,
// otherwise the stackless behaviour (CALL=JUMP, RET=HOLD, status tied low).

module tb_pc_sequencer;

   localparam int ADDR_W = 19;
   localparam int OFF_W  = 8;
   localparam int DEPTH  = 4;
   localparam int SP_W   = $clog2(DEPTH + 1);

`ifdef PC_SEQ_RET_STACK_EN
   localparam bit STK = 1'b1;
`else
   localparam bit STK = 1'b0;
`endif

   localparam logic [2:0] OP_HOLD   = 3'b000;
   localparam logic [2:0] OP_INC    = 3'b001;
   localparam logic [2:0] OP_JUMP   = 3'b010;
   localparam logic [2:0] OP_BRANCH = 3'b011;
   localparam logic [2:0] OP_CALL   = 3'b100;
   localparam logic [2:0] OP_RET    = 3'b101;
   localparam logic [2:0] OP_CLEAR  = 3'b110;
   localparam logic [2:0] OP_RSVD   = 3'b111;

   logic              clk_sys;
   logic              rst_n;
   logic              stall;
   logic [2:0]        op;
   logic              cond;
   logic [ADDR_W-1:0] target;
   logic [OFF_W-1:0]  offset;
   logic [ADDR_W-1:0] pc_out;
   logic [SP_W-1:0]   sp_out;
   logic              ovf;
   logic              unf;

   int n_checks = 0;
   int n_errors = 0;

   pc_sequencer #(
      .ADDR_W      (ADDR_W),
      .OFF_W       (OFF_W),
      .STACK_DEPTH (DEPTH),
      .RESET_VEC   (19'h00100)
   ) u_dut (
      .CLK       (clk_sys),
      .RESET_N   (rst_n),
      .STALL     (stall),
      .OP        (op),
      .COND      (cond),
      .TARGET    (target),
      .OFFSET    (offset),
      .PC_OUT    (pc_out),
      .SP_OUT    (sp_out),
      .OVERFLOW  (ovf),
      .UNDERFLOW (unf)
   );

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   typedef struct {
      logic              stall;
      logic [2:0]        op;
      logic              cond;
      logic [ADDR_W-1:0] target;
      logic [OFF_W-1:0]  offset;
      logic [ADDR_W-1:0] pc;
      logic [SP_W-1:0]   sp;
      logic              ovf;
      logic              unf;
   } vec_t;

   vec_t vecs[$];

   function automatic void v(input logic s, input logic [2:0] o, input logic c,
                             input logic [ADDR_W-1:0] t, input logic [OFF_W-1:0] f,
                             input logic [ADDR_W-1:0] p, input logic [SP_W-1:0] sp,
                             input logic ov, input logic un);
      vec_t r;
      r.stall = s; r.op = o; r.cond = c; r.target = t; r.offset = f;
      r.pc = p; r.sp = sp; r.ovf = ov; r.unf = un;
      vecs.push_back(r);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string nm, input logic [ADDR_W-1:0] p,
                          input logic [SP_W-1:0] sp, input logic ov, input logic un);
      chk({nm, " pc"},  32'(pc_out), 32'(p));
      chk({nm, " sp"},  32'(sp_out), 32'(sp));
      chk({nm, " ovf"}, 32'(ovf),    32'(ov));
      chk({nm, " unf"}, 32'(unf),    32'(un));
   endtask

   task automatic drive(input logic s, input logic [2:0] o, input logic c,
                        input logic [ADDR_W-1:0] t, input logic [OFF_W-1:0] f);
      @(negedge clk_sys);
      stall = s; op = o; cond = c; target = t; offset = f;
   endtask

   initial begin
      rst_n = 1'b0; stall = 1'b0; op = OP_HOLD; cond = 1'b0; target = '0; offset = '0;

      // Straight-line program from reset; each row is applied for one cycle.
      v(0, OP_INC,    0, 19'h0,     8'h00, 19'h00101, 0, 0, 0);
      v(0, OP_INC,    0, 19'h0,     8'h00, 19'h00102, 0, 0, 0);
      v(0, OP_INC,    0, 19'h0,     8'h00, 19'h00103, 0, 0, 0);
      v(0, OP_JUMP,   0, 19'h7FFFF, 8'h00, 19'h7FFFF, 0, 0, 0);
      v(0, OP_INC,    0, 19'h0,     8'h00, 19'h00000, 0, 0, 0);
      v(0, OP_JUMP,   0, 19'h00010, 8'h00, 19'h00010, 0, 0, 0);
      v(0, OP_BRANCH, 1, 19'h0,     8'h80, 19'h7FF90, 0, 0, 0);
      v(0, OP_BRANCH, 0, 19'h0,     8'h80, 19'h7FF91, 0, 0, 0);
      v(0, OP_BRANCH, 1, 19'h0,     8'h05, 19'h7FF96, 0, 0, 0);
      v(0, OP_HOLD,   0, 19'h12345, 8'h00, 19'h7FF96, 0, 0, 0);
      v(0, OP_RSVD,   1, 19'h12345, 8'h7F, 19'h7FF96, 0, 0, 0);
      v(0, OP_JUMP,   0, 19'h00050, 8'h00, 19'h00050, 0, 0, 0);
      v(0, OP_CALL,   0, 19'h00200, 8'h00, 19'h00200, STK ? 3'd1 : 3'd0, 0, 0);
      v(0, OP_RET,    0, 19'h0,     8'h00, STK ? 19'h00051 : 19'h00200, 0, 0, 0);
      v(0, OP_RET,    0, 19'h0,     8'h00, STK ? 19'h00051 : 19'h00200, 0, 0, STK);
      v(1, OP_JUMP,   0, 19'h00123, 8'h00, STK ? 19'h00051 : 19'h00200, 0, 0, STK);
      v(1, OP_CLEAR,  0, 19'h0,     8'h00, STK ? 19'h00051 : 19'h00200, 0, 0, STK);
      v(0, OP_CLEAR,  0, 19'h0,     8'h00, 19'h00100, 0, 0, 0);
      v(0, OP_CALL,   0, 19'h00300, 8'h00, 19'h00300, STK ? 3'd1 : 3'd0, 0, 0);
      v(0, OP_CALL,   0, 19'h00310, 8'h00, 19'h00310, STK ? 3'd2 : 3'd0, 0, 0);
      v(0, OP_CALL,   0, 19'h00320, 8'h00, 19'h00320, STK ? 3'd3 : 3'd0, 0, 0);
      v(0, OP_CALL,   0, 19'h00330, 8'h00, 19'h00330, STK ? 3'd4 : 3'd0, 0, 0);
      v(0, OP_CALL,   0, 19'h00340, 8'h00, STK ? 19'h00330 : 19'h00340, STK ? 3'd4 : 3'd0, STK, 0);
      v(0, OP_INC,    0, 19'h0,     8'h00, STK ? 19'h00331 : 19'h00341, STK ? 3'd4 : 3'd0, STK, 0);
      v(0, OP_RET,    0, 19'h0,     8'h00, STK ? 19'h00321 : 19'h00341, STK ? 3'd3 : 3'd0, STK, 0);
      v(0, OP_RET,    0, 19'h0,     8'h00, STK ? 19'h00311 : 19'h00341, STK ? 3'd2 : 3'd0, STK, 0);
      v(0, OP_RET,    0, 19'h0,     8'h00, STK ? 19'h00301 : 19'h00341, STK ? 3'd1 : 3'd0, STK, 0);
      v(0, OP_RET,    0, 19'h0,     8'h00, STK ? 19'h00101 : 19'h00341, 0, STK, 0);
      v(0, OP_CLEAR,  0, 19'h0,     8'h00, 19'h00100, 0, 0, 0);
      v(1, OP_CALL,   0, 19'h00999, 8'h00, 19'h00100, 0, 0, 0);

      repeat (2) @(posedge clk_sys);
      #1 chk_all("reset", 19'h00100, 0, 0, 0);
      @(negedge clk_sys);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].stall, vecs[i].op, vecs[i].cond, vecs[i].target, vecs[i].offset);
         @(posedge clk_sys);
         #1 chk_all($sformatf("vec%0d", i), vecs[i].pc, vecs[i].sp, vecs[i].ovf, vecs[i].unf);
      end

      // Underflow, then two calls, then asynchronous reset between clock edges.
      drive(0, OP_RET, 0, 19'h0, 8'h00);
      @(posedge clk_sys);
      #1 chk_all("pre_unf", 19'h00100, 0, 0, STK);
      drive(0, OP_CALL, 0, 19'h00400, 8'h00);
      @(posedge clk_sys);
      #1 chk_all("call1", 19'h00400, STK ? 3'd1 : 3'd0, 0, STK);
      drive(0, OP_CALL, 0, 19'h00410, 8'h00);
      @(posedge clk_sys);
      #1 chk_all("call2", 19'h00410, STK ? 3'd2 : 3'd0, 0, STK);
      #2 rst_n = 1'b0;
      #1 chk_all("async_rst", 19'h00100, 0, 0, 0);
      drive(0, OP_INC, 0, 19'h0, 8'h00);
      @(posedge clk_sys);
      #1 chk_all("rst_held", 19'h00100, 0, 0, 0);
      @(negedge clk_sys);
      rst_n = 1'b1;
      @(posedge clk_sys);
      #1 chk_all("post_rst_inc", 19'h00101, 0, 0, 0);
      drive(0, OP_RET, 0, 19'h0, 8'h00);
      @(posedge clk_sys);
      #1 chk_all("post_rst_ret", 19'h00101, 0, 0, STK);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
